// File: rtl/rv32i_dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_dmem_resp_pkg
// Description : Shared constants, state encoding and the access-legality
//               check for the rv32i data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_dmem_resp_pkg;

  // funct3 encodings for loads and stores (instr[14:12])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Responder FSM state encodings
  localparam logic [1:0] DMEM_IDLE   = 2'd0;
  localparam logic [1:0] DMEM_WAIT   = 2'd1;
  localparam logic [1:0] DMEM_ACCESS = 2'd2;
  localparam logic [1:0] DMEM_RESP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = DMEM_IDLE,
    ST_WAIT   = DMEM_WAIT,
    ST_ACCESS = DMEM_ACCESS,
    ST_RESP   = DMEM_RESP
  } dmem_state_e;

  // Returns 1 when the request has an illegal width or is misaligned.
  function automatic logic access_fault(input logic       is_write,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic bad_f3;
    logic misalign;
    if (is_write) begin
      bad_f3 = !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
    end else begin
      bad_f3 = !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                 f3 == F3_LBU || f3 == F3_LHU);
    end
    // Width lives in f3[1:0]; signedness bit does not affect alignment
    case (f3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
    return bad_f3 | misalign;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_load_ext
// Description : Combinational load-data lane select and sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_load_ext
  import rv32i_dmem_resp_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then extend according to funct3
  always_comb begin
    case (off_i)
      2'd0:    w_byte = raw_i[7:0];
      2'd1:    w_byte = raw_i[15:8];
      2'd2:    w_byte = raw_i[23:16];
      default: w_byte = raw_i[31:24];
    endcase
    w_half = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  data_o = {24'd0, w_byte};
      F3_LH:   data_o = {{16{w_half[15]}}, w_half};
      F3_LHU:  data_o = {16'd0, w_half};
      F3_LW:   data_o = raw_i;
      default: data_o = raw_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_dmem_resp
// Description : Data-memory responder for the rv32i core. Captures a LOAD or
//               STORE, waits WAIT_CYCLES, accesses a byte-lane word array and
//               returns extended load data with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_dmem_resp
  import rv32i_dmem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        fault
);

  localparam int         DEPTH       = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_RELOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e         state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [2:0]          f3_q, f3_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                flt_q, flt_d;
  logic [31:0]         raw_q;
  logic                done_q, fault_q;
  logic [31:0]         mem_q [DEPTH];

  logic                w_req;
  logic                w_fault;
  logic [3:0]          w_be;
  logic [31:0]         w_wd;
  logic [31:0]         w_ext;
  logic [ADDR_W-1:0]   w_idx;

  // Upper address bits alias onto the array and are deliberately dropped
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, addr[31:ADDR_W+2]};

  assign w_req   = mem_read | mem_write;
  assign w_fault = access_fault(mem_write, funct3, addr[1:0]);
  assign w_idx   = addr_q[ADDR_W+1:2];

  // Next-state logic: capture in IDLE, count wait states, then access/respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    flt_d   = flt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          addr_d  = addr[ADDR_W+1:0];
          f3_d    = funct3;
          wdata_d = wdata;
          wr_d    = mem_write;
          flt_d   = w_fault;
          if (w_fault) begin
            state_d = ST_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_RELOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, captured request and registered response flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      flt_q   <= 1'b0;
      raw_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      flt_q   <= flt_d;
      done_q  <= (state_d == ST_RESP);
      fault_q <= (state_d == ST_RESP) & flt_d;
      if (state_q == ST_ACCESS && !wr_q) begin
        raw_q <= mem_q[w_idx];
      end
    end
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    w_be = 4'b0000;
    w_wd = wdata_q;
    case (f3_q)
      F3_SB: begin
        w_be = 4'b0001 << addr_q[1:0];
        w_wd = {4{wdata_q[7:0]}};
      end
      F3_SH: begin
        w_be = addr_q[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{wdata_q[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  // Array write happens only in ACCESS, so a reset before then drops the store
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_ACCESS && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          mem_q[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
        end
      end
    end
  end

  rv32i_load_ext u_load_ext (
    .raw_i    (raw_q),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (w_ext)
  );

  assign rdata = (state_q == ST_RESP && !wr_q && !flt_q) ? w_ext : 32'd0;
  assign stall = (state_q == ST_IDLE && w_req) || state_q == ST_WAIT ||
                 state_q == ST_ACCESS;
  assign done  = done_q;
  assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_dmem_resp
// Description : Self-checking bench for rv32i_dmem_resp with WAIT_CYCLES of
//               1, 0 and 4 on three instances sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_dmem_resp;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ef;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        mem_read, mem_write, stall, done, fault;
  logic [2:0][2:0]   funct3;
  logic [2:0][31:0]  addr, wdata, rdata;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv32i_dmem_resp #(
      .ADDR_W      (10),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .funct3    (funct3[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .rdata     (rdata[g]),
      .stall     (stall[g]),
      .done      (done[g]),
      .fault     (fault[g])
    );
  end

  function automatic int wc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 4);
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive one request on instance d, wait (bounded) for done, score it
  task automatic do_access(input int d, input vec_t v);
    exp_t e;
    exp_t g;
    int   cyc;
    logic stall_ok;
    e.rdata = v.er;
    e.fault = v.ef;
    e.lat   = v.ef ? 1 : 2 + wc(d);
    sb_q.push_back(e);
    @(negedge clk);
    mem_write[d] = v.wr;
    mem_read[d]  = v.rd;
    funct3[d]    = v.f3;
    addr[d]      = v.a;
    wdata[d]     = v.wd;
    #1;
    stall_ok = (stall[d] === 1'b1);
    cyc = 0;
    while (cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        // Inputs after IDLE must be ignored: drop strobes and scramble the rest
        mem_write[d] = 1'b0;
        mem_read[d]  = 1'b0;
        funct3[d]    = 3'b111;
        addr[d]      = 32'hFFFF_FFFF;
        wdata[d]     = 32'h0BAD_0BAD;
      end
      if (done[d] === 1'b1) break;
      if (stall[d] !== 1'b1) stall_ok = 1'b0;
    end
    g = sb_q.pop_front();
    if (done[d] !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done on dut %0d after %0d cycles, expected at %0d", d, cyc, g.lat);
    end else begin
      check32("latency", 32'(cyc), 32'(g.lat));
      check32("rdata", rdata[d], g.rdata);
      check1("fault", fault[d], g.fault);
      check1("stall_pending", stall_ok, 1'b1);
      check1("stall_resp", stall[d], 1'b0);
      @(posedge clk);
      #1;
      check1("done_pulse", done[d], 1'b0);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ef);
    vec_t v;
    v.wr = wr; v.rd = rd; v.f3 = f3; v.a = a; v.wd = wd; v.er = er; v.ef = ef;
    return v;
  endfunction

  initial begin
    // Vector table for the WAIT_CYCLES=1 instance
    tbl.push_back(mk(1, 0, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0)); // SW
    tbl.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0)); // LW
    tbl.push_back(mk(0, 1, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 0)); // LB
    tbl.push_back(mk(0, 1, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0)); // LBU
    tbl.push_back(mk(0, 1, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 0)); // LH
    tbl.push_back(mk(0, 1, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 0)); // LHU
    tbl.push_back(mk(1, 0, 3'b000, 32'h11,   32'hAAAAAA55, 32'h0,        0)); // SB
    tbl.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 0));
    tbl.push_back(mk(1, 0, 3'b001, 32'h12,   32'hFFFF1234, 32'h0,        0)); // SH
    tbl.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        32'h123455EF, 0));
    tbl.push_back(mk(0, 1, 3'b010, 32'h12,   32'h0,        32'h0,        1)); // LW misaligned
    tbl.push_back(mk(1, 0, 3'b001, 32'h11,   32'h0000BBBB, 32'h0,        1)); // SH misaligned
    tbl.push_back(mk(0, 1, 3'b011, 32'h10,   32'h0,        32'h0,        1)); // load f3=011
    tbl.push_back(mk(1, 0, 3'b100, 32'h10,   32'h77777777, 32'h0,        1)); // store f3=100
    tbl.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        32'h123455EF, 0)); // unchanged
    tbl.push_back(mk(0, 1, 3'b000, 32'h10,   32'h0,        32'hFFFFFFEF, 0));
    tbl.push_back(mk(0, 1, 3'b000, 32'h11,   32'h0,        32'h00000055, 0));
    tbl.push_back(mk(0, 1, 3'b101, 32'h10,   32'h0,        32'h000055EF, 0));
    tbl.push_back(mk(0, 1, 3'b001, 32'h10,   32'h0,        32'h000055EF, 0));
    tbl.push_back(mk(0, 1, 3'b010, 32'h1010, 32'h0,        32'h123455EF, 0)); // alias
    tbl.push_back(mk(1, 1, 3'b010, 32'h30,   32'hCAFEF00D, 32'h0,        0)); // both strobes
    tbl.push_back(mk(0, 1, 3'b010, 32'h30,   32'h0,        32'hCAFEF00D, 0));
    tbl.push_back(mk(1, 0, 3'b000, 32'h33,   32'h00000080, 32'h0,        0));
    tbl.push_back(mk(0, 1, 3'b000, 32'h33,   32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'h20,   32'h11111111, 32'h0,        0));

    rst       = 1'b1;
    mem_read  = '0;
    mem_write = '0;
    funct3    = '0;
    addr      = '0;
    wdata     = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_done", done[0], 1'b0);
    check1("reset_fault", fault[0], 1'b0);
    check32("reset_rdata", rdata[0], 32'h0);
    check1("reset_stall", stall[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) do_access(0, tbl[i]);

    // Reset during WAIT of a store: the store must be discarded
    @(negedge clk);
    mem_write[0] = 1'b1;
    funct3[0]    = 3'b010;
    addr[0]      = 32'h20;
    wdata[0]     = 32'h99999999;
    @(posedge clk);
    #1;
    mem_write[0] = 1'b0;
    check1("wait_stall", stall[0], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("rst_mid_done", done[0], 1'b0);
    check1("rst_mid_fault", fault[0], 1'b0);
    check32("rst_mid_rdata", rdata[0], 32'h0);
    check1("rst_mid_stall", stall[0], 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check1("rst_after_done", done[0], 1'b0);
    do_access(0, mk(0, 1, 3'b010, 32'h20, 32'h0, 32'h11111111, 0));

    // WAIT_CYCLES=0 and WAIT_CYCLES=4 instances
    do_access(1, mk(1, 0, 3'b010, 32'h40, 32'hA5A50F0F, 32'h0,        0));
    do_access(1, mk(0, 1, 3'b001, 32'h42, 32'h0,        32'hFFFFA5A5, 0));
    do_access(2, mk(1, 0, 3'b010, 32'h40, 32'h3C3C7E7E, 32'h0,        0));
    do_access(2, mk(0, 1, 3'b100, 32'h41, 32'h0,        32'h0000007E, 0));
    do_access(2, mk(0, 1, 3'b010, 32'h42, 32'h0,        32'h0,        1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32i_dmem_resp.md
# rv32i_dmem_resp

Data-memory responder for the rv32i core: the target end of the `mem_read`/`mem_write` strobes issued by the main controller. It captures the address, store data and `funct3` width for a LOAD or STORE, and performs the access on a byte-addressable word array after a configurable number of wait states. It returns sign- or zero-extended load data and holds the core with `stall` until the access completes. Misaligned accesses and illegal widths are flagged with `fault` and do not touch memory.

## Interface
- `ADDR_W`, default 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 1: wait states inserted before the array access; legal range 0..15.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset; synchronous, active-high.
- `mem_read` input, 1 bit: load request, level, from the main controller.
- `mem_write` input, 1 bit: store request, level, from the main controller.
- `funct3` input, 3 bits: access width and signedness, instr[14:12].
- `addr` input, 32 bits: byte address, the ALU result.
- `wdata` input, 32 bits: store data, rs2.
- `rdata` output, 32 bits: extended load data; valid while `done`=1.
- `stall` output, 1 bit: holds PC and pipeline while an access is pending.
- `done` output, 1 bit: one-cycle pulse when the access completes.
- `fault` output, 1 bit: qualifies `done`; the access was misaligned or had an illegal `funct3`.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- **IDLE**
  - A request is `mem_read|mem_write`. When one is present, capture `addr`, `funct3`, `wdata` and the operation; if both strobes are high, the write takes priority.
  - Fault check on the captured request:
    - `funct3` must be in {000,001,010,100,101} for loads and {000,001,010} for stores; anything else is a fault.
    - Halfword access needs addr[0]=0; word access needs addr[1:0]=00; otherwise it is a fault.
  - On fault, go to RESP with the fault flag set. Otherwise go to WAIT and load the counter with WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to ACCESS.
- **WAIT**: decrement the counter; go to ACCESS when it reads 0.
- **ACCESS**: single-cycle array operation at word index addr[ADDR_W+1:2]. Address bits above ADDR_W+1 are ignored (aliasing).
  - Store byte enables:
    - SB: one lane selected by addr[1:0], data = wdata[7:0] replicated.
    - SH: lanes {1,0} or {3,2} selected by addr[1], data = wdata[15:0].
    - SW: all four lanes.
  - Load: register the raw word and the lane offset.
  - Then go to RESP.
- **RESP**: `done`=1 and `stall`=0.
  - Loads: `rdata` = extended value. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Stores: `rdata` = 0.
  - Faults: `rdata` = 0 and `fault`=1.
  - Next state is IDLE unconditionally. A request still present in that IDLE cycle is treated as a new access; the core has advanced its PC during RESP.
- `stall` = (state==IDLE & request) | state==WAIT | state==ACCESS.
- Reset mid-operation: the FSM returns to IDLE and a pending store is discarded, because the array is only written in ACCESS. Array contents are not reset.

## Timing
- Reset values: `rdata`=0, `done`=0, `fault`=0, `stall`=0 (when no request), FSM state=IDLE, counter=0.
- Request first seen in IDLE at cycle 0:
  - Good access: ACCESS at cycle 1+WAIT_CYCLES, `done` at cycle 2+WAIT_CYCLES, `stall` high in cycles 0..1+WAIT_CYCLES.
  - Fault: `done`/`fault` at cycle 1, `stall` high in cycle 0 only.
- A store is visible to a load whose ACCESS state falls in a later cycle; there are no read/write collisions, since only one access is in flight.
- Request inputs are sampled only in IDLE; changes during WAIT/ACCESS/RESP are ignored.
- `done` and `fault` are registered; `stall` is combinational from the state and the strobes.

## Structure
- `rv32i_defs.vh` gains:
  - `F3_LB/LH/LW/LBU/LHU/SB/SH/SW` constants.
  - `DMEM_IDLE/WAIT/ACCESS/RESP` 2-bit state encodings.
- Sub-module `rv32i_load_ext`: combinational; (raw word, offset, `funct3`) -> 32-bit extended data. The FSM, counter, byte-lane write and array stay in the top module.

## Test plan
- WAIT_CYCLES=1, SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> store `done` at cycle 3 with `stall` high in cycles 0..2; load `done` with `rdata`=0xDEADBEEF, `fault`=0.
- After that word, loads at addr=0x13 -> LB gives 0xFFFFFFDE, LBU 0x000000DE; loads at addr=0x12 -> LH gives 0xFFFFDEAD, LHU 0x0000DEAD.
- SB addr=0x11 wdata=0x55, then LW 0x10 -> 0xDEAD55EF. SH addr=0x12 wdata=0x1234, then LW -> 0x123455EF.
- LW addr=0x12, or SH addr=0x11, or load `funct3`=011 -> `done`=`fault`=1 at cycle 1, `rdata`=0, memory word unchanged.
- WAIT_CYCLES=0, then WAIT_CYCLES=4 -> `done` at cycles 2 and 6; `mem_read` and `mem_write` both high -> behaves as a store.
- Assert `rst` during WAIT of an SW to 0x20 -> outputs go to 0, state IDLE, subsequent LW 0x20 returns the old contents.
